// File: rtl/kbd_codes_pkg.sv
// Scan codes, decoder state encoding and held-vector indices shared by the
// keyboard command logic.
package kbd_codes_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  localparam int KI_SPACE = 0;
  localparam int KI_A     = 1;
  localparam int KI_D     = 2;
  localparam int KI_P     = 3;
  localparam int KI_H     = 4;
  localparam int NUM_KEYS = 5;

  // One-hot held-vector position of a tracked make code; zero for anything else.
  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit = '0;
    case (code)
      SC_SPACE: hit[KI_SPACE] = 1'b1;
      SC_A:     hit[KI_A]     = 1'b1;
      SC_D:     hit[KI_D]     = 1'b1;
      SC_P:     hit[KI_P]     = 1'b1;
      SC_H:     hit[KI_H]     = 1'b1;
      default:  hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_cmd_sequencer_btn_sync.sv
// Two-flop synchronizer bringing a raw push-button into the clk domain.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      dout     <= 1'b0;
    end else begin
      meta_reg <= din;
      dout     <= meta_reg;
    end
  end

endmodule

// File: rtl/key_cmd_sequencer.sv
// PS/2 scan-code decoder: make/break/extended prefix FSM, per-key held state,
// and the pause/help/velocity/jump commands derived from it.
module key_cmd_sequencer
  import kbd_codes_pkg::*;
#(
  parameter int VEL_MIN        = 1,
  parameter int VEL_MAX        = 3,
  parameter int VEL_INIT       = 2,
  parameter int PREFIX_TIMEOUT = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       btn,
  output logic       jump,
  output logic       pause,
  output logic       help,
  output logic [1:0] velocity,
  output logic       key_event
);

  localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  dec_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NUM_KEYS-1:0] held_reg, held_next;
  logic [NUM_KEYS-1:0] new_make, new_break;
  logic pause_next, help_next, jump_next, key_event_next;
  logic [1:0] velocity_next;
  logic btn_s;

  btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .din   (btn),
    .dout  (btn_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A pending prefix is abandoned after PREFIX_TIMEOUT silent cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    if (state_reg == IDLE) begin
      if (scan_valid) begin
        if (scan_code == SC_BREAK)    state_next = BRK;
        else if (scan_code == SC_EXT) state_next = EXT;
      end
    end else if (scan_valid) begin
      if (state_reg == EXT && scan_code == SC_BREAK) state_next = EXT_BRK;
      else                                           state_next = IDLE;
    end else if (cnt_reg == CNT_LAST) begin
      state_next = IDLE;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_comb begin
    new_make  = '0;
    new_break = '0;
    if (scan_valid && state_reg == IDLE) new_make  = key_onehot(scan_code) & ~held_reg;
    if (scan_valid && state_reg == BRK)  new_break = key_onehot(scan_code) & held_reg;
    held_next      = (held_reg | new_make) & ~new_break;
    key_event_next = |{new_make, new_break};

    pause_next    = pause ^ new_make[KI_P];
    help_next     = help ^ new_make[KI_H];
    velocity_next = velocity;
    if (new_make[KI_A] && !pause && velocity < 2'(VEL_MAX))
      velocity_next = velocity + 2'd1;
    else if (new_make[KI_D] && !pause && velocity > 2'(VEL_MIN))
      velocity_next = velocity - 2'd1;

    // Built from next-cycle values so a SPACE strobe shows on jump one cycle later.
    jump_next = (held_next[KI_SPACE] | btn_s) & ~pause_next & ~help_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_reg  <= '0;
      pause     <= 1'b0;
      help      <= 1'b0;
      velocity  <= 2'(VEL_INIT);
      jump      <= 1'b0;
      key_event <= 1'b0;
    end else begin
      held_reg  <= held_next;
      pause     <= pause_next;
      help      <= help_next;
      velocity  <= velocity_next;
      jump      <= jump_next;
      key_event <= key_event_next;
    end
  end

endmodule

// File: tb/tb_key_cmd_sequencer.sv
// Directed bench for key_cmd_sequencer: a one-vector-per-cycle table plus
// hand-written prefix-timeout and reset-collision sequences.
module tb_key_cmd_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       btn;
  logic       jump, pause, help, key_event;
  logic [1:0] velocity;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       b;
    logic       jump;
    logic       pause;
    logic       help;
    logic [1:0] vel;
    logic       kev;
  } vec_t;

  vec_t vecs[$];

  key_cmd_sequencer #(
    .VEL_MIN        (1),
    .VEL_MAX        (3),
    .VEL_INIT       (2),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .btn        (btn),
    .jump       (jump),
    .pause      (pause),
    .help       (help),
    .velocity   (velocity),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [7:0] code, input logic b,
                     input logic j, input logic p, input logic h,
                     input logic [1:0] vel, input logic kev);
    vec_t t;
    t.v = v; t.code = code; t.b = b; t.jump = j; t.pause = p;
    t.help = h; t.vel = vel; t.kev = kev;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic j, input logic p,
                         input logic h, input logic [1:0] vel, input logic kev);
    chk({tag, ".jump"}, idx, int'(jump), int'(j));
    chk({tag, ".pause"}, idx, int'(pause), int'(p));
    chk({tag, ".help"}, idx, int'(help), int'(h));
    chk({tag, ".velocity"}, idx, int'(velocity), int'(vel));
    chk({tag, ".key_event"}, idx, int'(key_event), int'(kev));
    $display("%s step %0d: valid=%0d code=%h btn=%0d -> jump=%0d pause=%0d help=%0d vel=%0d kev=%0d",
             tag, idx, scan_valid, scan_code, btn, jump, pause, help, velocity, key_event);
  endtask

  // Present one byte (or idle) for exactly one clock, then sample 1 time unit later.
  task automatic step(input logic v, input logic [7:0] code, input logic b);
    scan_valid = v;
    scan_code  = code;
    btn        = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; btn = 1'b0;

    // Speed up, saturate at 3, back down to 2; six A events.
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'hF0, 0, 0, 0, 0, 3, 0);
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'hF0, 0, 0, 0, 0, 3, 0);
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'hF0, 0, 0, 0, 0, 3, 0);
    add(1, 8'h1C, 0, 0, 0, 0, 3, 1);
    add(1, 8'h23, 0, 0, 0, 0, 2, 1);
    add(1, 8'hF0, 0, 0, 0, 0, 2, 0);
    add(1, 8'h23, 0, 0, 0, 0, 2, 1);
    add(0, 8'h00, 0, 0, 0, 0, 2, 0);
    // Pause toggle with typematic repeats.
    add(1, 8'h4D, 0, 0, 1, 0, 2, 1);
    for (int i = 0; i < 5; i++) add(1, 8'h4D, 0, 0, 1, 0, 2, 0);
    add(1, 8'hF0, 0, 0, 1, 0, 2, 0);
    add(1, 8'h4D, 0, 0, 1, 0, 2, 1);
    add(1, 8'h4D, 0, 0, 0, 0, 2, 1);
    add(1, 8'hF0, 0, 0, 0, 0, 2, 0);
    add(1, 8'h4D, 0, 0, 0, 0, 2, 1);
    // SPACE jump; extended break must not release it.
    add(1, 8'h29, 0, 1, 0, 0, 2, 1);
    add(1, 8'hE0, 0, 1, 0, 0, 2, 0);
    add(1, 8'hF0, 0, 1, 0, 0, 2, 0);
    add(1, 8'h29, 0, 1, 0, 0, 2, 0);
    add(1, 8'hF0, 0, 1, 0, 0, 2, 0);
    add(1, 8'h29, 0, 0, 0, 0, 2, 1);
    // Button reaches jump on the third cycle.
    add(0, 8'h00, 1, 0, 0, 0, 2, 0);
    add(0, 8'h00, 1, 0, 0, 0, 2, 0);
    add(0, 8'h00, 1, 1, 0, 0, 2, 0);
    // Paused: speed keys frozen, help toggles, jump masked.
    add(1, 8'h4D, 1, 0, 1, 0, 2, 1);
    add(1, 8'hF0, 1, 0, 1, 0, 2, 0);
    add(1, 8'h4D, 1, 0, 1, 0, 2, 1);
    add(1, 8'h23, 1, 0, 1, 0, 2, 1);
    add(1, 8'hF0, 1, 0, 1, 0, 2, 0);
    add(1, 8'h23, 1, 0, 1, 0, 2, 1);
    add(1, 8'h1C, 1, 0, 1, 0, 2, 1);
    add(1, 8'hF0, 1, 0, 1, 0, 2, 0);
    add(1, 8'h1C, 1, 0, 1, 0, 2, 1);
    add(1, 8'h33, 1, 0, 1, 1, 2, 1);
    add(1, 8'hF0, 1, 0, 1, 1, 2, 0);
    add(1, 8'h33, 1, 0, 1, 1, 2, 1);
    add(1, 8'h4D, 1, 0, 0, 1, 2, 1);
    add(1, 8'hF0, 1, 0, 0, 1, 2, 0);
    add(1, 8'h4D, 1, 0, 0, 1, 2, 1);
    add(1, 8'h33, 1, 1, 0, 0, 2, 1);
    add(1, 8'hF0, 1, 1, 0, 0, 2, 0);
    add(1, 8'h33, 1, 1, 0, 0, 2, 1);
    // Button release also takes three cycles to reach jump.
    add(0, 8'h00, 0, 1, 0, 0, 2, 0);
    add(0, 8'h00, 0, 1, 0, 0, 2, 0);
    add(0, 8'h00, 0, 0, 0, 0, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 2, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].code, vecs[i].b);
      chk_all("table", i, vecs[i].jump, vecs[i].pause, vecs[i].help, vecs[i].vel, vecs[i].kev);
    end

    // F0 still pending one cycle before timeout: 29 is a break of an unheld key.
    step(1, 8'hF0, 0);
    for (int i = 0; i < TO - 2; i++) step(0, 8'h00, 0);
    step(1, 8'h29, 0);
    chk_all("to_short", 0, 0, 0, 0, 2, 0);

    // F0 abandoned after TO idle cycles: 29 becomes a make.
    step(1, 8'hF0, 0);
    for (int i = 0; i < TO; i++) step(0, 8'h00, 0);
    step(1, 8'h29, 0);
    chk_all("to_full", 0, 1, 0, 0, 2, 1);
    step(1, 8'hF0, 0);
    step(1, 8'h29, 0);
    chk_all("to_full", 1, 0, 0, 0, 2, 1);

    // Reset colliding with a P make while a break prefix is pending.
    step(1, 8'h1C, 0);
    step(1, 8'hF0, 0);
    step(1, 8'h1C, 0);
    step(1, 8'h4D, 0);
    chk_all("rst_mid", 0, 0, 1, 0, 3, 1);
    step(1, 8'hF0, 0);
    reset = 1'b1;
    step(1, 8'h4D, 0);
    chk_all("rst_mid", 1, 0, 0, 0, 2, 0);
    reset = 1'b0;
    step(1, 8'h29, 0);
    chk_all("rst_mid", 2, 1, 0, 0, 2, 1);
    step(1, 8'h4D, 0);
    chk_all("rst_mid", 3, 0, 1, 0, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_sequencer.md
Name: key_cmd_sequencer

Overview:
- Turns the raw PS/2 scan-code stream into clean game commands: jump level, pause/help toggles, saturating speed level.
- Sits between the PS/2 byte reader and the game core.
- Decodes make/break/extended prefixes with a small FSM and tracks per-key held state, so typematic repeats never re-trigger toggles or speed steps.
- Merges the board push-button into the jump command.

Parameters:
- VEL_MIN, 1, lowest speed level
- VEL_MAX, 3, highest speed level
- VEL_INIT, 2, speed level after reset
- PREFIX_TIMEOUT, 25000, clk cycles a pending prefix survives without a following byte (1 ms at 25 MHz)

Ports:
- clk  in  1  system clock (25 MHz game clock)
- reset  in  1  synchronous, active-high reset
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte
- scan_code  in  8  byte from PS/2 reader
- btn  in  1  raw asynchronous push-button, active-high
- jump  out  1  jump request level
- pause  out  1  pause toggle state
- help  out  1  help-screen toggle state
- velocity  out  2  current speed level
- key_event  out  1  one-cycle pulse on every accepted make/break of a tracked key

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and wins over every other input in the same cycle.
- Reset values: jump=0, pause=0, help=0, velocity=VEL_INIT, key_event=0, FSM=IDLE, all held bits=0, timeout counter=0, btn synchronizer=0.
- Tracked keys (make codes): SPACE 8'h29, A 8'h1C, D 8'h23, P 8'h4D, H 8'h33. Each has a held bit.
- Decoder FSM, advanced only on scan_valid:
  - IDLE:
    - 8'hF0 -> BRK
    - 8'hE0 -> EXT
    - tracked code -> make(code), stay IDLE
    - any other byte -> ignored
  - BRK: any byte -> break(code) if tracked, then IDLE.
  - EXT:
    - 8'hF0 -> EXT_BRK
    - any other byte -> ignored, IDLE
  - EXT_BRK: any byte -> ignored (extended keys are never tracked), IDLE. So E0 F0 29 must not release SPACE.
- Timeout:
  - In BRK, EXT or EXT_BRK the counter increments every cycle without scan_valid.
  - When it reaches PREFIX_TIMEOUT-1, the FSM returns to IDLE and the counter clears.
  - The counter also clears on every scan_valid and whenever the FSM is in IDLE.
- make(k):
  - If held[k]=0: set held[k], pulse key_event, perform the key action.
  - If held[k]=1 (typematic repeat): no action, no pulse.
- break(k):
  - If held[k]=1: clear held[k], pulse key_event.
  - A break for a key that is not held is ignored.
- Key actions on make, registered, visible the cycle after scan_valid:
  - P: pause <= ~pause.
  - H: help <= ~help (allowed while paused).
  - A: if pause=0 and velocity<VEL_MAX, velocity+1; otherwise unchanged (saturates).
  - D: if pause=0 and velocity>VEL_MIN, velocity-1; otherwise unchanged.
  - SPACE: held bit only.
- btn path: 2-flop synchronizer, then btn_s.
- jump = registered (held[SPACE] | btn_s) & ~pause & ~help. Latency: 1 cycle from the key strobe; 3 cycles from btn.
- A/D pressed together: each make is its own byte and is processed in arrival order; only one byte can arrive per cycle.
- Reset mid-prefix (e.g. after F0): FSM returns to IDLE and all held bits clear, so the following raw 29 is treated as a make.

Decomposition:
- Shared package kbd_codes_pkg holds:
  - scan-code localparams: SC_SPACE, SC_A, SC_D, SC_P, SC_H, SC_BREAK=8'hF0, SC_EXT=8'hE0
  - FSM state encoding: IDLE=2'd0, BRK=2'd1, EXT=2'd2, EXT_BRK=2'd3
  - key index constants for the held vector (5 bits)
- One natural sub-module: btn_sync (2-flop synchronizer; reusable for the game's other buttons).
- The decoder FSM and the action logic stay in key_cmd_sequencer.

Test Plan:
- Reset, then strobe 1C, F0 1C, 1C, F0 1C, 1C, F0 1C -> velocity 2->3->3->3 (saturates); key_event pulses 6 times.
- Strobe 4D, then 4D repeated 5x (typematic), then F0 4D -> pause=1 after the first byte, stays 1; a second 4D, F0 4D -> pause=0.
- Strobe 29 -> jump=1 one cycle later; E0 F0 29 -> jump stays 1; F0 29 -> jump=0. Hold btn=1 with no keys -> jump=1 on the 3rd cycle.
- With pause=1: strobe 23, F0 23 -> velocity unchanged at 2; strobe 33 -> help=1, jump forced 0 even while btn=1.
- Strobe F0, then idle PREFIX_TIMEOUT cycles, then 29 -> treated as a make: held[SPACE]=1, jump=1.
- Assert reset in the same cycle as scan_valid with 4D, with pause=1 beforehand -> pause=0, velocity=2, FSM=IDLE next cycle; the byte is dropped.
